vgm_sequencer: RTL and testbench
================================

VGM_SEQUENCER -- requirements
Module: vgm_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_SAMPLE, default 567, meaning in_clk cycles per 44.1 kHz VGM sample (25 MHz clock).
REQ-002 SHALL have parameter WR_HIGH_CYCLES, default 2, meaning cycles out_wr is held high per PSG register write; legal range 1..15.
REQ-003 SHALL have one clock, in_clk (input, 1), rising-edge.
REQ-004 SHALL have in_rst (input, 1), synchronous, active-high reset.
REQ-005 SHALL have in_data (input, 8), the next byte of the VGM command stream.
REQ-006 SHALL have in_valid (input, 1), meaning in_data holds a valid byte.
REQ-007 SHALL have out_ready (output, 1); a byte is consumed on a cycle where in_valid and out_ready are both 1.
REQ-008 SHALL have in_run (input, 1), which permits fetching of new commands.
REQ-009 SHALL have out_reg (output, 4), the PSG register index.
REQ-010 SHALL have out_val (output, 8), the PSG register value.
REQ-011 SHALL have out_wr (output, 1), the PSG write strobe; the PSG samples on the rising edge.
REQ-012 SHALL have out_busy (output, 1), high in every state except FETCH_CMD, DONE and ERROR.
REQ-013 SHALL have out_done (output, 1), sticky, set when opcode 0x66 is executed.
REQ-014 SHALL have out_error (output, 1), sticky, set when an unknown opcode is fetched.

Function
REQ-015 SHALL implement the states FETCH_CMD, FETCH_A1, FETCH_A2, WR_HIGH, WR_LOW, WAIT, DONE and ERROR.
REQ-016 SHALL assert out_ready = in_run in FETCH_CMD, FETCH_A1 and FETCH_A2, and 0 in all other states.
REQ-017 SHALL decode opcodes in FETCH_CMD as follows:
- 0xA0: go to FETCH_A1, which fetches aa, then FETCH_A2, which fetches dd.
- 0x61: fetch n_lo, then n_hi, and wait n samples.
- 0x62: wait 735 samples.
- 0x63: wait 882 samples.
- 0x66: go to DONE.
- Any other opcode: go to ERROR.
REQ-018 SHALL handle dd accepted with aa < 0x10 as a write:
- On the next edge, load out_reg = aa[3:0] and out_val = dd and raise out_wr.
- Hold out_wr high for exactly WR_HIGH_CYCLES cycles (WR_HIGH).
- Then drive out_wr low for exactly 1 cycle (WR_LOW), then return to FETCH_CMD.
REQ-019 SHALL handle aa >= 0x10 (including second-chip aa[7]=1) by dropping the write: no out_wr pulse, out_reg and out_val unchanged, return to FETCH_CMD on the next edge.
REQ-020 SHALL make a wait of n samples last exactly n*CLKS_PER_SAMPLE cycles in WAIT, then enter FETCH_CMD; the sample divider restarts on WAIT entry.
REQ-021 SHALL treat n = 0 as no WAIT: go directly to FETCH_CMD on the edge after the last argument.
REQ-022 SHALL use a 16-bit sample counter and a divider of width $clog2(CLKS_PER_SAMPLE); neither counter wraps, because both are checked for terminal count.
REQ-023 SHALL freeze only fetching when in_run=0; an in-progress write pulse or wait completes, and argument fetches stall without losing state.
REQ-024 SHALL treat DONE and ERROR as terminal: out_ready=0 and out_wr=0 until in_rst.
REQ-025 SHALL keep out_wr low in every state except WR_HIGH, so consecutive writes are always separated by at least one low cycle.

Reset
REQ-026 SHALL on in_rst: state=FETCH_CMD, out_wr=0, out_reg=0, out_val=0, out_done=0, out_error=0, counters=0.
REQ-027 SHALL give in_rst priority over all events; asserting it mid-WR_HIGH or mid-WAIT drops out_wr and aborts the command at the next edge.
REQ-028 SHALL drive out_ready=0 during the reset cycle.

Configuration
REQ-029 SHALL, with VGM_SEQ_SHORTWAIT_EN defined, decode opcodes 0x70..0x7F as a wait of (opcode[3:0]+1) samples with no argument bytes.
REQ-030 SHALL, without VGM_SEQ_SHORTWAIT_EN, treat 0x70..0x7F as unknown opcodes and go to ERROR.

Structure
REQ-031 SHALL place the opcode constants (0xA0, 0x61, 0x62, 0x63, 0x66, 0x70), the wait constants 735 and 882, and the state enumeration in the package vgm_seq_pkg.
REQ-032 SHALL implement the per-sample divider as the sub-module vgm_sample_tick (in_clk, in_rst, in_clr, out_tick), with the tick 1 cycle wide every CLKS_PER_SAMPLE cycles.

Verification
REQ-033 SHALL cover: stream A0 07 3E with in_valid always 1 -> out_reg=7 and out_val=0x3E, out_wr high 2 cycles, then low 1 cycle, with out_ready=0 during the pulse.
REQ-034 SHALL cover: 61 03 00 then A0 00 10 -> the write strobe rises exactly 3*567 cycles (+ fixed fetch latency) after the 0x00 byte is accepted.
REQ-035 SHALL cover: 61 00 00 then 66 -> no WAIT cycles, and out_done=1 two cycles later with out_ready=0 thereafter.
REQ-036 SHALL cover: A0 13 55 -> no out_wr pulse, out_reg and out_val unchanged, and the next opcode accepted.
REQ-037 SHALL cover: 75 -> a 6-sample wait (3402 cycles) with VGM_SEQ_SHORTWAIT_EN defined, and out_error=1 without it.
REQ-038 SHALL cover: in_rst asserted on the 2nd WR_HIGH cycle -> out_wr=0 at the next edge, and the state is FETCH_CMD with all flags clear.

Source files
------------

// File: rtl/vgm_seq_pkg.sv
// Shared opcode, wait-length and state definitions for the VGM command sequencer.
// The 0x70..0x7F short-wait opcodes are decoded only when VGM_SEQ_SHORTWAIT_EN is defined.
package vgm_seq_pkg;

  localparam logic [7:0] OP_WRITE      = 8'hA0;
  localparam logic [7:0] OP_WAIT_N     = 8'h61;
  localparam logic [7:0] OP_WAIT_735   = 8'h62;
  localparam logic [7:0] OP_WAIT_882   = 8'h63;
  localparam logic [7:0] OP_END        = 8'h66;
  localparam logic [7:0] OP_SHORT_WAIT = 8'h70;

  localparam logic [15:0] WAIT_735 = 16'd735;
  localparam logic [15:0] WAIT_882 = 16'd882;

  typedef enum logic [2:0] {
    ST_FETCH_CMD = 3'd0,
    ST_FETCH_A1  = 3'd1,
    ST_FETCH_A2  = 3'd2,
    ST_WR_HIGH   = 3'd3,
    ST_WR_LOW    = 3'd4,
    ST_WAIT      = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  function automatic logic is_fetch_state(input state_t s);
    return (s == ST_FETCH_CMD) || (s == ST_FETCH_A1) || (s == ST_FETCH_A2);
  endfunction

endpackage

// File: rtl/vgm_sample_tick.sv
// Per-sample divider: emits a one-cycle tick every CLKS_PER_SAMPLE clocks while in_clr is low.
module vgm_sample_tick #(
  parameter int CLKS_PER_SAMPLE = 567
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clr,
  output logic out_tick
);

  localparam int DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);

  logic [DIV_W-1:0] div_q;

  // Divider restarts from zero whenever cleared, then counts 0..CLKS_PER_SAMPLE-1.
  always_ff @(posedge in_clk) begin
    if (in_rst || in_clr) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign out_tick = !in_clr && (div_q == DIV_LAST);

endmodule

// File: rtl/vgm_sequencer.sv
// VGM command-stream sequencer driving PSG register writes and sample-accurate waits.
// Build option: VGM_SEQ_SHORTWAIT_EN enables the 0x7n one-byte short-wait opcodes.
module vgm_sequencer
  import vgm_seq_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 567,
  parameter int WR_HIGH_CYCLES  = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic       in_run,
  output logic [3:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error
);

  localparam logic [3:0] WR_LAST = 4'(WR_HIGH_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  arg1_q;
  logic        cmd_wait_q;
  logic [15:0] samp_q;
  logic [3:0]  hcnt_q;
  logic [3:0]  reg_q;
  logic [7:0]  val_q;
  logic        wr_q;
  logic        done_q;
  logic        error_q;
  logic        tick_s;
  logic        accept_s;

  vgm_sample_tick #(.CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)) u_tick (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clr   (state_q != ST_WAIT),
    .out_tick (tick_s)
  );

  assign accept_s = in_valid && in_run;

  // Command FSM; all PSG-facing outputs and sticky flags are registered here.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= ST_FETCH_CMD;
      arg1_q     <= 8'd0;
      cmd_wait_q <= 1'b0;
      samp_q     <= 16'd0;
      hcnt_q     <= 4'd0;
      reg_q      <= 4'd0;
      val_q      <= 8'd0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH_CMD: begin
          if (accept_s) begin
            case (in_data)
              OP_WRITE:    begin cmd_wait_q <= 1'b0; state_q <= ST_FETCH_A1; end
              OP_WAIT_N:   begin cmd_wait_q <= 1'b1; state_q <= ST_FETCH_A1; end
              OP_WAIT_735: begin samp_q <= WAIT_735; state_q <= ST_WAIT; end
              OP_WAIT_882: begin samp_q <= WAIT_882; state_q <= ST_WAIT; end
              OP_END:      begin done_q <= 1'b1; state_q <= ST_DONE; end
              default: begin
`ifdef VGM_SEQ_SHORTWAIT_EN
                if (in_data[7:4] == OP_SHORT_WAIT[7:4]) begin
                  samp_q  <= {12'd0, in_data[3:0]} + 16'd1;
                  state_q <= ST_WAIT;
                end else begin
                  error_q <= 1'b1;
                  state_q <= ST_ERROR;
                end
`else
                error_q <= 1'b1;
                state_q <= ST_ERROR;
`endif
              end
            endcase
          end
        end
        ST_FETCH_A1: begin
          if (accept_s) begin
            arg1_q  <= in_data;
            state_q <= ST_FETCH_A2;
          end
        end
        ST_FETCH_A2: begin
          if (accept_s) begin
            if (cmd_wait_q) begin
              // n = {n_hi, n_lo}; a zero-length wait skips WAIT entirely.
              if ({in_data, arg1_q} == 16'd0) begin
                state_q <= ST_FETCH_CMD;
              end else begin
                samp_q  <= {in_data, arg1_q};
                state_q <= ST_WAIT;
              end
            end else if (arg1_q[7:4] == 4'd0) begin
              reg_q   <= arg1_q[3:0];
              val_q   <= in_data;
              wr_q    <= 1'b1;
              hcnt_q  <= 4'd0;
              state_q <= ST_WR_HIGH;
            end else begin
              state_q <= ST_FETCH_CMD;
            end
          end
        end
        ST_WR_HIGH: begin
          if (hcnt_q == WR_LAST) begin
            wr_q    <= 1'b0;
            state_q <= ST_WR_LOW;
          end else begin
            hcnt_q <= hcnt_q + 4'd1;
          end
        end
        ST_WR_LOW: begin
          hcnt_q  <= 4'd0;
          state_q <= ST_FETCH_CMD;
        end
        ST_WAIT: begin
          if (tick_s) begin
            if (samp_q <= 16'd1) begin
              samp_q  <= 16'd0;
              state_q <= ST_FETCH_CMD;
            end else begin
              samp_q <= samp_q - 16'd1;
            end
          end
        end
        ST_DONE:  state_q <= ST_DONE;
        ST_ERROR: state_q <= ST_ERROR;
        default: begin
          wr_q    <= 1'b0;
          error_q <= 1'b1;
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  assign out_ready = in_run && !in_rst && is_fetch_state(state_q);
  assign out_busy  = !((state_q == ST_FETCH_CMD) || (state_q == ST_DONE) || (state_q == ST_ERROR));
  assign out_reg   = reg_q;
  assign out_val   = val_q;
  assign out_wr    = wr_q;
  assign out_done  = done_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_vgm_sequencer.sv
// Directed-vector bench for vgm_sequencer with hand-computed expectations.
module tb_vgm_sequencer;

  logic       clk = 1'b0;
  logic       in_rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       in_run;
  logic [3:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_busy;
  logic       out_done;
  logic       out_error;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int t0;
  int cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vgm_sequencer #(.CLKS_PER_SAMPLE(567), .WR_HIGH_CYCLES(2)) dut (
    .in_clk   (clk),
    .in_rst   (in_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_run   (in_run),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_error(out_error)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (n < 2000) begin
      @(negedge clk);
      if (out_ready) break;
      n++;
    end
    if (n >= 2000) check_vec("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic count_not_ready(output int c);
    c = 0;
    while (!out_ready && c < 5000) begin
      step();
      c++;
    end
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    step();
  endtask

  initial begin
    in_rst = 1'b1; in_run = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    check_vec("rst_ready", out_ready, 0);
    check_vec("rst_wr",    out_wr,    0);
    check_vec("rst_reg",   out_reg,   0);
    check_vec("rst_val",   out_val,   0);
    check_vec("rst_done",  out_done,  0);
    check_vec("rst_error", out_error, 0);
    check_vec("rst_busy",  out_busy,  0);
    in_rst = 1'b0;
    step();
    check_vec("idle_ready", out_ready, 1);

    // A0 07 3E: write reg 7, two high cycles then one low cycle.
    send_byte(8'hA0); send_byte(8'h07); send_byte(8'h3E);
    check_vec("wr1_wr",    out_wr,    1);
    check_vec("wr1_reg",   out_reg,   4'h7);
    check_vec("wr1_val",   out_val,   8'h3E);
    check_vec("wr1_ready", out_ready, 0);
    check_vec("wr1_busy",  out_busy,  1);
    step();
    check_vec("wr1_high2",  out_wr,    1);
    check_vec("wr1_ready2", out_ready, 0);
    step();
    check_vec("wr1_low",       out_wr,    0);
    check_vec("wr1_low_ready", out_ready, 0);
    check_vec("wr1_low_busy",  out_busy,  1);
    step();
    check_vec("wr1_fetch_ready", out_ready, 1);
    check_vec("wr1_fetch_busy",  out_busy,  0);

    // Out-of-range addresses are dropped.
    send_byte(8'hA0); send_byte(8'h13); send_byte(8'h55);
    check_vec("drop13_wr",    out_wr,    0);
    check_vec("drop13_reg",   out_reg,   4'h7);
    check_vec("drop13_val",   out_val,   8'h3E);
    check_vec("drop13_ready", out_ready, 1);
    send_byte(8'hA0); send_byte(8'h80); send_byte(8'h11);
    check_vec("drop80_wr",  out_wr,  0);
    check_vec("drop80_val", out_val, 8'h3E);
    send_byte(8'hA0); send_byte(8'h0F); send_byte(8'hAA);
    check_vec("wr0f_wr",  out_wr,  1);
    check_vec("wr0f_reg", out_reg, 4'hF);
    check_vec("wr0f_val", out_val, 8'hAA);
    step(); step(); step();

    // in_run low stalls an argument fetch without losing the opcode.
    send_byte(8'hA0);
    in_run = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    step(); step(); step();
    check_vec("stall_ready", out_ready, 0);
    check_vec("stall_busy",  out_busy,  1);
    check_vec("stall_wr",    out_wr,    0);
    in_run = 1'b1;
    send_byte(8'h05); send_byte(8'h66);
    check_vec("stall_wr_after", out_wr,  1);
    check_vec("stall_reg",      out_reg, 4'h5);
    check_vec("stall_val",      out_val, 8'h66);
    step(); step(); step();

    // 61 03 00: 3-sample wait, then A0 00 10.
    send_byte(8'h61); send_byte(8'h03); send_byte(8'h00);
    t0 = cyc;
    check_vec("wait3_busy", out_busy, 1);
    count_not_ready(cnt);
    check_vec("wait3_cycles", cnt, 1701);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h10);
    check_vec("wait3_wr",      out_wr,   1);
    check_vec("wait3_reg",     out_reg,  4'h0);
    check_vec("wait3_val",     out_val,  8'h10);
    check_vec("wait3_latency", cyc - t0, 1704);
    step(); step(); step();

    // Short-wait opcode 0x75.
    send_byte(8'h75);
`ifdef VGM_SEQ_SHORTWAIT_EN
    count_not_ready(cnt);
    check_vec("short_cycles", cnt, 3402);
    check_vec("short_error",  out_error, 0);
`else
    check_vec("short_error", out_error, 1);
    check_vec("short_ready", out_ready, 0);
    check_vec("short_busy",  out_busy,  0);
`endif
    do_reset();
    check_vec("post_rst_error", out_error, 0);

    // 61 00 00 then 66: no wait, then terminal DONE.
    send_byte(8'h61); send_byte(8'h00); send_byte(8'h00);
    t0 = cyc;
    check_vec("wait0_ready", out_ready, 1);
    check_vec("wait0_busy",  out_busy,  0);
    send_byte(8'h66);
    check_vec("done_latency", cyc - t0, 1);
    check_vec("done_flag",    out_done,  1);
    check_vec("done_ready",   out_ready, 0);
    check_vec("done_busy",    out_busy,  0);
    in_valid = 1'b1; in_data = 8'hA0;
    step(); step();
    check_vec("done_hold_ready", out_ready, 0);
    check_vec("done_hold_flag",  out_done,  1);
    check_vec("done_hold_wr",    out_wr,    0);
    in_valid = 1'b0;
    do_reset();

    // Unknown opcode goes to ERROR.
    send_byte(8'h55);
    check_vec("unk_error", out_error, 1);
    check_vec("unk_done",  out_done,  0);
    check_vec("unk_ready", out_ready, 0);
    do_reset();

    // Reset on the second WR_HIGH cycle aborts the pulse.
    send_byte(8'hA0); send_byte(8'h01); send_byte(8'h22);
    step();
    check_vec("prerst_wr", out_wr, 1);
    in_rst = 1'b1;
    step();
    check_vec("midrst_wr",    out_wr,    0);
    check_vec("midrst_reg",   out_reg,   0);
    check_vec("midrst_val",   out_val,   0);
    check_vec("midrst_busy",  out_busy,  0);
    check_vec("midrst_done",  out_done,  0);
    check_vec("midrst_error", out_error, 0);
    check_vec("midrst_ready", out_ready, 0);
    in_rst = 1'b0;
    step();
    check_vec("midrst_fetch_ready", out_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
